// File: rtl/led_ctrl_pkg.sv
// Shared mode codes, FSM state encoding and reset divider value for the LED sequencer.
package led_ctrl_pkg;

    localparam int unsigned MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF    = 3'd0;
    localparam mode_t MODE_ROTL   = 3'd1;
    localparam mode_t MODE_ROTR   = 3'd2;
    localparam mode_t MODE_BOUNCE = 3'd3;
    localparam mode_t MODE_BLINK  = 3'd4;
    localparam mode_t MODE_FILL   = 3'd5;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam int unsigned DIV_DEFAULT = 5000000;

    // True for modes that animate; OFF and the reserved codes park in S_OFF.
    function automatic logic mode_runs(input mode_t m);
        return (m != MODE_OFF) && (m <= MODE_FILL);
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_step_divider.sv
// Programmable step divider: tick fires every div+1 enabled cycles.
module step_divider #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    input  logic [CNT_W-1:0] div,
    output logic             tick
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear dominates hold so a reload always restarts the period from zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (!hold) begin
            if (count_q == div) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = !clr && !hold && (count_q == div);

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank pattern sequencer with valid/ready command port and step divider.
// Optional brightness PWM is built when LED_PWM_EN is defined.
module led_pattern_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DIV_DEFAULT = led_ctrl_pkg::DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_div,
    input  logic             pause,
`ifdef LED_PWM_EN
    input  logic [3:0]       brightness,
`endif
    output logic [WIDTH-1:0] led,
    output logic             step_pulse
);
    import led_ctrl_pkg::*;

    state_e           state_q;
    mode_t            mode_q;
    logic [CNT_W-1:0] div_q;
    logic [WIDTH-1:0] led_q;
    logic             dir_q;
    logic             step_pulse_q;
    logic             cmd_ready_q;

    logic             cmd_accept;
    logic             tick;
    logic [WIDTH-1:0] step_led_c;
    logic             step_dir_c;

    assign cmd_accept = cmd_valid && cmd_ready_q;

    step_divider #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != S_RUN),
        .hold (pause),
        .div  (div_q),
        .tick (tick)
    );

    function automatic logic [WIDTH-1:0] seed_of(input mode_t m);
        logic [WIDTH-1:0] s;
        s = '0;
        case (m)
            MODE_ROTL:   s = WIDTH'(1);
            MODE_ROTR:   s = {1'b1, {(WIDTH-1){1'b0}}};
            MODE_BOUNCE: s = WIDTH'(1);
            MODE_BLINK:  s = '1;
            default:     s = '0;
        endcase
        return s;
    endfunction

    // Next LED/direction for one pattern advance; bounce turns around on the end bit.
    always_comb begin
        step_led_c = led_q;
        step_dir_c = dir_q;
        case (mode_q)
            MODE_ROTL:   step_led_c = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            MODE_ROTR:   step_led_c = {led_q[0], led_q[WIDTH-1:1]};
            MODE_BOUNCE: begin
                if (!dir_q) begin
                    if (led_q[WIDTH-1]) begin
                        step_dir_c = 1'b1;
                        step_led_c = led_q >> 1;
                    end else begin
                        step_led_c = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        step_dir_c = 1'b0;
                        step_led_c = led_q << 1;
                    end else begin
                        step_led_c = led_q >> 1;
                    end
                end
            end
            MODE_BLINK:  step_led_c = ~led_q;
            MODE_FILL:   step_led_c = {led_q[WIDTH-2:0], ~led_q[WIDTH-1]};
            default:     step_led_c = led_q;
        endcase
    end

    // Pattern FSM; an accepted command always beats a coincident step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_OFF;
            mode_q       <= MODE_OFF;
            div_q        <= CNT_W'(DIV_DEFAULT);
            led_q        <= '0;
            dir_q        <= 1'b0;
            step_pulse_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            step_pulse_q <= 1'b0;
            case (state_q)
                S_OFF: begin
                    led_q <= '0;
                    if (cmd_accept) begin
                        mode_q      <= cmd_mode;
                        div_q       <= cmd_div;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    led_q       <= seed_of(mode_q);
                    dir_q       <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= mode_runs(mode_q) ? S_RUN : S_OFF;
                end
                S_RUN: begin
                    if (cmd_accept) begin
                        mode_q      <= cmd_mode;
                        div_q       <= cmd_div;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_LOAD;
                    end else if (tick) begin
                        led_q        <= step_led_c;
                        dir_q        <= step_dir_c;
                        step_pulse_q <= 1'b1;
                    end
                end
                default: begin
                    led_q       <= '0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_OFF;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign step_pulse = step_pulse_q;

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 4'(1);
        end
    end

    assign led = led_q & {WIDTH{pwm_cnt_q < brightness}};
`else
    assign led = led_q;
`endif

endmodule
